// File: rtl/conv2d_64ch_maxpool_reader_pkg.sv
// Shared constants, types and address helper for the 64-channel max-pool reader.
// Constants reflect the default 11x11x64 geometry; the top recomputes them from its parameters.
package conv2d_pool_pkg;

   localparam int IN_H_DEF    = 11;
   localparam int IN_W_DEF    = 11;
   localparam int CH_DEF      = 64;
   localparam int WPP         = CH_DEF / 4;
   localparam int OUT_H       = IN_H_DEF / 2;
   localparam int OUT_W       = IN_W_DEF / 2;
   localparam int TOTAL_WORDS = OUT_H * OUT_W * WPP;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      OUT,
      DONE
   } state_t;

   // Four signed int8 channels, lane 0 in bits [7:0].
   typedef logic [3:0][7:0] word4_t;

   function automatic logic [31:0] pix_addr(input logic [31:0] base, input int in_w,
                                            input int wpp, input int r, input int c,
                                            input int w);
      return base + 32'(((r * in_w + c) * wpp + w) * 4);
   endfunction

endpackage

// File: rtl/conv2d_64ch_maxpool_reader_if.sv
// BRAM port B and pooled-output stream bundle of the max-pool reader.
interface conv2d_64ch_maxpool_reader_if;
   logic [31:0] BRAM_PORTB_0_addr;
   logic        BRAM_PORTB_0_en;
   logic [3:0]  BRAM_PORTB_0_we;
   logic [31:0] BRAM_PORTB_0_din;
   logic [31:0] BRAM_PORTB_0_dout;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   modport master (
      output BRAM_PORTB_0_addr, BRAM_PORTB_0_en, BRAM_PORTB_0_we, BRAM_PORTB_0_din,
      output m_data, m_valid, m_last,
      input  BRAM_PORTB_0_dout, m_ready
   );

   modport slave (
      input  BRAM_PORTB_0_addr, BRAM_PORTB_0_en, BRAM_PORTB_0_we, BRAM_PORTB_0_din,
      input  m_data, m_valid, m_last,
      output BRAM_PORTB_0_dout, m_ready
   );
endinterface

// File: rtl/conv2d_64ch_maxpool_reader_max4x8_lane.sv
// Registered lane-wise signed max of an accumulator word and an input word.
// preset loads -128 into every lane and takes priority over fold.
module max4x8_lane
   import conv2d_pool_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   preset,
   input  logic   fold,
   input  word4_t din,
   output word4_t acc
);

   word4_t acc_q;
   word4_t acc_d;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign acc_d[gi] = preset ? 8'h80 :
                            (fold && ($signed(din[gi]) > $signed(acc_q[gi]))) ? din[gi] :
                            acc_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv2d_64ch_maxpool_reader.sv
// 2x2 stride-2 max pooling over an int8 feature map read through BRAM port B, streamed as 4-lane words.
// Optional build macro MAXPOOL_RELU_EN clamps each output lane to max(lane, 0).
module conv2d_64ch_maxpool_reader
   import conv2d_pool_pkg::*;
#(
   parameter int          IN_H      = 11,
   parameter int          IN_W      = 11,
   parameter int          CH        = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          RD_LAT    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   conv2d_64ch_maxpool_reader_if.master bus
);

   localparam int WPP_L = CH / 4;
   localparam int OH_L  = IN_H / 2;
   localparam int OW_L  = IN_W / 2;

   state_t        state_q, state_d;
   logic [1:0]    rd_idx_q, rd_idx_d;
   logic [1:0]    drain_q, drain_d;
   logic [15:0]   w_q, w_d, ocol_q, ocol_d, orow_q, orow_d;
   logic          en_q, en_d;
   logic [31:0]   addr_q, addr_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [RD_LAT-1:0] tag_q, tag_d;
   logic          preset;
   logic          is_last;
   logic [15:0]   nw, nocol, norow;
   word4_t        acc_word;

   // Read k of a quad: bit 1 selects the lower source row, bit 0 the right source column.
   function automatic logic [31:0] src_addr(input logic [15:0] orow, input logic [15:0] ocol,
                                            input logic [15:0] w, input logic [1:0] k);
      return pix_addr(BASE_ADDR, IN_W, WPP_L, 2 * int'(orow) + int'(k[1]),
                      2 * int'(ocol) + int'(k[0]), int'(w));
   endfunction

   assign is_last = (orow_q == 16'(OH_L - 1)) && (ocol_q == 16'(OW_L - 1)) &&
                    (w_q == 16'(WPP_L - 1));

   always_comb begin
      nw    = w_q + 16'd1;
      nocol = ocol_q;
      norow = orow_q;
      if (w_q == 16'(WPP_L - 1)) begin
         nw    = 16'd0;
         nocol = ocol_q + 16'd1;
         if (ocol_q == 16'(OW_L - 1)) begin
            nocol = 16'd0;
            norow = orow_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_idx_d  = rd_idx_q;
      drain_d   = drain_q;
      w_d       = w_q;
      ocol_d    = ocol_q;
      orow_d    = orow_q;
      en_d      = 1'b0;
      addr_d    = addr_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      preset    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = READ;
               rd_idx_d = 2'd0;
               drain_d  = 2'd0;
               w_d      = 16'd0;
               ocol_d   = 16'd0;
               orow_d   = 16'd0;
               busy_d   = 1'b1;
               en_d     = 1'b1;
               addr_d   = src_addr(16'd0, 16'd0, 16'd0, 2'd0);
            end
         end
         READ: begin
            preset = (rd_idx_q == 2'd0);
            if (rd_idx_q == 2'd3) begin
               state_d = DRAIN;
               drain_d = 2'd0;
            end else begin
               rd_idx_d = rd_idx_q + 2'd1;
               en_d     = 1'b1;
               addr_d   = src_addr(orow_q, ocol_q, w_q, rd_idx_q + 2'd1);
            end
         end
         DRAIN: begin
            if (drain_q == 2'(RD_LAT - 1)) begin
               state_d   = OUT;
               m_valid_d = 1'b1;
               m_last_d  = is_last;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         OUT: begin
            if (bus.m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (is_last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = READ;
                  rd_idx_d = 2'd0;
                  w_d      = nw;
                  ocol_d   = nocol;
                  orow_d   = norow;
                  en_d     = 1'b1;
                  addr_d   = src_addr(norow, nocol, nw, 2'd0);
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Tag pipeline follows en so returned data is folded only in the cycle it lands.
   generate
      if (RD_LAT == 1) begin : g_tag1
         assign tag_d = en_q;
      end else begin : g_tagn
         assign tag_d = {tag_q[RD_LAT-2:0], en_q};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_idx_q  <= '0;
         drain_q   <= '0;
         w_q       <= '0;
         ocol_q    <= '0;
         orow_q    <= '0;
         en_q      <= 1'b0;
         addr_q    <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tag_q     <= '0;
      end else begin
         state_q   <= state_d;
         rd_idx_q  <= rd_idx_d;
         drain_q   <= drain_d;
         w_q       <= w_d;
         ocol_q    <= ocol_d;
         orow_q    <= orow_d;
         en_q      <= en_d;
         addr_q    <= addr_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tag_q     <= tag_d;
      end
   end

   max4x8_lane u_max (
      .clk    (clk),
      .rst    (rst),
      .preset (preset),
      .fold   (tag_q[RD_LAT-1]),
      .din    (bus.BRAM_PORTB_0_dout),
      .acc    (acc_word)
   );

`ifdef MAXPOOL_RELU_EN
   word4_t relu_word;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_relu
         assign relu_word[gi] = acc_word[gi][7] ? 8'h00 : acc_word[gi];
      end
   endgenerate
   assign bus.m_data = relu_word;
`else
   assign bus.m_data = acc_word;
`endif

   assign bus.BRAM_PORTB_0_addr = addr_q;
   assign bus.BRAM_PORTB_0_en   = en_q;
   assign bus.BRAM_PORTB_0_we   = 4'b0000;
   assign bus.BRAM_PORTB_0_din  = 32'h0;
   assign bus.m_valid           = m_valid_q;
   assign bus.m_last            = m_last_q;
   assign busy                  = busy_q;
   assign done                  = done_q;

endmodule

// File: tb/tb_conv2d_64ch_maxpool_reader.sv
// Bench for conv2d_64ch_maxpool_reader: BRAM model, pooled-output reference model and a per-cycle monitor.
module tb_conv2d_64ch_maxpool_reader;
   import conv2d_pool_pkg::*;

   parameter int RD_LAT = 1;
   localparam int          IN_H  = 11;
   localparam int          IN_W  = 11;
   localparam logic [31:0] BASE  = 32'h0;
   localparam int          NWORD = IN_H * IN_W * WPP;
`ifdef MAXPOOL_RELU_EN
   localparam logic [7:0] LANE2_EXP = 8'h00;
`else
   localparam logic [7:0] LANE2_EXP = 8'hFF;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic done;

   conv2d_64ch_maxpool_reader_if bus ();

   conv2d_64ch_maxpool_reader #(.RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          word_idx = 0;
   int          done_cnt = 0;
   bit          done_exp = 1'b0;
   bit          stall_prev = 1'b0;
   bit          mon_en = 1'b0;
   bit          rdy_rand = 1'b0;
   logic [31:0] prev_data = '0;
   logic [31:0] first_word = '0;
   logic [31:0] last_word = '0;
   logic [31:0] mem [0:NWORD-1];
   logic [31:0] exp_words [0:TOTAL_WORDS-1];
   logic [31:0] rd_pipe [0:RD_LAT-1];
   logic [31:0] mem_idx;
   logic        addr_ok;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (word %0d, t=%0t)", name, act, req, word_idx, $time);
      end
   endtask

   // BRAM port B: garbage is returned on cycles that were not enabled.
   assign mem_idx = (bus.BRAM_PORTB_0_addr - BASE) >> 2;
   assign addr_ok = (bus.BRAM_PORTB_0_addr[1:0] == 2'b00) && (mem_idx < 32'(NWORD));
   always @(posedge clk) begin
      rd_pipe[0] <= (bus.BRAM_PORTB_0_en && addr_ok) ? mem[mem_idx] : $urandom();
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.BRAM_PORTB_0_dout = rd_pipe[RD_LAT-1];

   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic fill_mem(input int mode);
      for (int r = 0; r < IN_H; r++)
         for (int c = 0; c < IN_W; c++)
            for (int w = 0; w < WPP; w++) begin
               logic [7:0] pv;
               pv = 8'((r * IN_W + c) & 8'h7F);
               mem[(r * IN_W + c) * WPP + w] = (mode == 0) ? {4{pv}} : $urandom();
            end
      if (mode != 0) begin
         mem[(0 * IN_W + 0) * WPP][23:16] = 8'hFB;
         mem[(0 * IN_W + 1) * WPP][23:16] = 8'h80;
         mem[(1 * IN_W + 0) * WPP][23:16] = 8'hFF;
         mem[(1 * IN_W + 1) * WPP][23:16] = 8'h9C;
      end
   endtask

   task automatic build_model();
      int idx = 0;
      for (int orow = 0; orow < OUT_H; orow++)
         for (int ocol = 0; ocol < OUT_W; ocol++)
            for (int w = 0; w < WPP; w++) begin
               for (int l = 0; l < 4; l++) begin
                  int m = -128;
                  for (int q = 0; q < 4; q++) begin
                     logic [31:0] src;
                     byte         v;
                     src = mem[((2 * orow + q / 2) * IN_W + 2 * ocol + q % 2) * WPP + w];
                     v   = src[8*l +: 8];
                     if (int'(v) > m) m = int'(v);
                  end
`ifdef MAXPOOL_RELU_EN
                  if (m < 0) m = 0;
`endif
                  exp_words[idx][8*l +: 8] = 8'(m);
               end
               idx++;
            end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         done_exp   = 1'b0;
      end else if (mon_en) begin
         if (stall_prev) begin
            check(bus.m_valid == 1'b1, "stall_valid_hold", 32'(bus.m_valid), 32'd1);
            check(bus.m_data == prev_data, "stall_data_hold", bus.m_data, prev_data);
         end
         if (bus.m_valid && !bus.m_ready)
            check(bus.BRAM_PORTB_0_en == 1'b0, "en_in_stall", 32'(bus.BRAM_PORTB_0_en), 32'd0);
         if (bus.BRAM_PORTB_0_en)
            check(addr_ok, "addr_range", bus.BRAM_PORTB_0_addr, BASE);
         if (!bus.m_valid)
            check(bus.m_last == 1'b0, "last_without_valid", 32'(bus.m_last), 32'd0);
         check(done == done_exp, "done_timing", 32'(done), 32'(done_exp));
         if (done) done_cnt++;
         done_exp = 1'b0;
         if (bus.m_valid && bus.m_ready) begin
            if (word_idx >= TOTAL_WORDS) begin
               check(1'b0, "extra_word", 32'(word_idx), 32'(TOTAL_WORDS));
            end else begin
               check(bus.m_data == exp_words[word_idx], "word_data", bus.m_data,
                     exp_words[word_idx]);
               check(bus.m_last == (word_idx == TOTAL_WORDS - 1), "word_last",
                     32'(bus.m_last), 32'(word_idx == TOTAL_WORDS - 1));
               if (word_idx == 0) first_word = bus.m_data;
               if (word_idx == TOTAL_WORDS - 1) begin
                  last_word = bus.m_data;
                  done_exp  = 1'b1;
               end
               word_idx++;
            end
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
      end
   end

   task automatic clear_tracking();
      word_idx   = 0;
      done_cnt   = 0;
      done_exp   = 1'b0;
      stall_prev = 1'b0;
   endtask

   task automatic pulse_start_and_check_latency();
      int n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check(busy == 1'b1, "busy_after_start", 32'(busy), 32'd1);
      while (!bus.m_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(n == 4 + RD_LAT, "first_valid_latency", 32'(n), 32'(4 + RD_LAT));
   endtask

   task automatic run_pass(input bit inject_start);
      int n = 0;
      bit injected = 1'b0;
      clear_tracking();
      pulse_start_and_check_latency();
      while (done_cnt == 0 && n < 20000) begin
         @(posedge clk); #1;
         if (inject_start && !injected && word_idx >= 10) begin
            start    = 1'b1;
            injected = 1'b1;
         end else begin
            start = 1'b0;
         end
         n++;
      end
      start = 1'b0;
      if (n >= 20000) check(1'b0, "pass_timeout", 32'(word_idx), 32'(TOTAL_WORDS));
      repeat (10) @(posedge clk);
      @(negedge clk);
      check(word_idx == TOTAL_WORDS, "word_count", 32'(word_idx), 32'(TOTAL_WORDS));
      check(done_cnt == 1, "done_count", 32'(done_cnt), 32'd1);
      check(busy == 1'b0, "busy_after_done", 32'(busy), 32'd0);
      check(bus.m_valid == 1'b0, "valid_after_done", 32'(bus.m_valid), 32'd0);
   endtask

   task automatic reset_mid_pass(input int at_word);
      int n = 0;
      clear_tracking();
      pulse_start_and_check_latency();
      while (word_idx < at_word && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 20000) check(1'b0, "reset_wait_timeout", 32'(word_idx), 32'(at_word));
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check(bus.m_valid == 1'b0, "valid_after_rst", 32'(bus.m_valid), 32'd0);
      check(busy == 1'b0, "busy_after_rst", 32'(busy), 32'd0);
      check(done == 1'b0, "done_after_rst", 32'(done), 32'd0);
      repeat (8) @(negedge clk);
      check(done_cnt == 0, "no_done_after_rst", 32'(done_cnt), 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      fill_mem(0);
      build_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check(bus.m_valid == 1'b0, "rst_m_valid", 32'(bus.m_valid), 32'd0);
      check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
      check(done == 1'b0, "rst_done", 32'(done), 32'd0);
      check(bus.BRAM_PORTB_0_en == 1'b0, "rst_en", 32'(bus.BRAM_PORTB_0_en), 32'd0);
      check(bus.BRAM_PORTB_0_addr == 32'h0, "rst_addr", bus.BRAM_PORTB_0_addr, 32'h0);
      check(bus.m_data == 32'h0, "rst_m_data", bus.m_data, 32'h0);
      check(bus.m_last == 1'b0, "rst_m_last", 32'(bus.m_last), 32'd0);
      check(bus.BRAM_PORTB_0_we == 4'b0000, "tied_we", 32'(bus.BRAM_PORTB_0_we), 32'd0);
      check(bus.BRAM_PORTB_0_din == 32'h0, "tied_din", bus.BRAM_PORTB_0_din, 32'h0);
      mon_en = 1'b1;

      // Index-pattern map: pixel (1,1) = 12 and pixel (9,9) = 108 win their quads.
      run_pass(1'b0);
      check(first_word == 32'h0C0C0C0C, "pattern_first_word", first_word, 32'h0C0C0C0C);
      check(last_word == 32'h6C6C6C6C, "pattern_last_word", last_word, 32'h6C6C6C6C);

      // Random map with lane 2 of word 0 forced to {-5, -128, -1, -100}.
      fill_mem(1);
      build_model();
      run_pass(1'b0);
      check(first_word[23:16] == LANE2_EXP, "quad_lane2", 32'(first_word[23:16]),
            32'(LANE2_EXP));

      rdy_rand = 1'b1;
      run_pass(1'b0);

      reset_mid_pass(37);
      run_pass(1'b0);

      rdy_rand = 1'b0;
      fill_mem(1);
      build_model();
      run_pass(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv2d_64ch_maxpool_reader.md
Name: conv2d_64ch_maxpool_reader

Overview:
- Downstream consumer of the Conv2D_2 64-channel output BRAM. Reads the 11x11x64 int8 feature map through BRAM port B and performs 2x2 stride-2 max pooling.
- Streams the 5x5x64 pooled result as packed 32-bit words over a valid/ready interface to the flatten/dense stage.
- Operates on one clock domain. Port B of the BRAM is clocked by the same clk at top level.

Parameters:
- IN_H, 11, input feature-map height.
- IN_W, 11, input feature-map width.
- CH, 64, channel count. Must be a multiple of 4.
- BASE_ADDR, 32'h0, byte address of element (0,0,word 0) in the BRAM.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a pooling pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final output handshake.
- BRAM_PORTB_0_addr  out  32  byte read address.
- BRAM_PORTB_0_en  out  1  read enable.
- BRAM_PORTB_0_we  out  4  tied 4'b0000.
- BRAM_PORTB_0_din  out  32  tied 0.
- BRAM_PORTB_0_dout  in  32  read data, 4 signed int8 channels packed, lane0 in [7:0].
- m_data  out  32  pooled word, 4 int8 lanes.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with the final word of the pass.

Behaviour:
- Constants:
  - WPP = CH/4 words per pixel (16).
  - OUT_H = IN_H/2 (floor, 5); OUT_W = IN_W/2 (floor, 5).
  - Total output words = OUT_H*OUT_W*WPP (400).
- Input layout: addr(r,c,w) = BASE_ADDR + ((r*IN_W + c)*WPP + w)*4.
- Output order: out-row major, then out-col, then word w. For output (orow, ocol, w), the four source pixels are (2orow,2ocol), (2orow,2ocol+1), (2orow+1,2ocol), (2orow+1,2ocol+1).
- Odd trailing row or column (row 10, col 10) is never read.
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- FSM states:
  - IDLE: on start go to READ, clear counters, busy<=1.
  - READ: issue 4 consecutive reads, one per cycle, en=1, in the source order above. Then go to DRAIN.
  - DRAIN: wait RD_LAT cycles. The last read's data is folded into the lane-wise signed max accumulator. Then go to OUT.
  - OUT: m_valid=1 and m_data held stable until m_ready. On handshake: advance w, then ocol, then orow, and return to READ. If that was the final word, go to DONE.
  - DONE: pulse done=1, busy<=0, return to IDLE.
- Accumulator: each of the 4 lanes is preset to 8'h80 (-128) when the first read issues. Each returned word performs lane-wise signed max, 8 bits, no widening.
- Data-return tracking: a RD_LAT-deep valid tag pipeline marks which cycles carry returned data. Data is sampled only on tagged cycles.
- Latency: first m_valid 4+RD_LAT cycles after start (5 for RD_LAT=1). With m_ready held high, throughput is one word per 4+RD_LAT+1 cycles.
- en is 0 in every state except READ. Address is held at its last value when en=0.
- Backpressure: while m_valid && !m_ready, no reads are issued and m_data does not change.
- m_last=1 only with the final word's m_valid.
- start is ignored while busy or in DONE.
- rst asserted mid-pass: next cycle is IDLE, m_valid=0, done is not pulsed. Returned data still in flight is discarded.

Optional Feature:
- MAXPOOL_RELU_EN defined: each output lane is clamped with max(lane, 0) after pooling. The clamp is combinational on m_data and adds no latency.
- MAXPOOL_RELU_EN undefined: signed max values pass unchanged, negatives included.

Decomposition:
- Package conv2d_pool_pkg holds:
  - Constants WPP, OUT_H, OUT_W, TOTAL_WORDS.
  - State enum typedef (IDLE, READ, DRAIN, OUT, DONE).
  - Packed typedef for 4 int8 lanes.
  - Address-computation function.
- One sub-module: max4x8_lane, a registered lane-wise signed max of an accumulator word and an input word, with a preset input.

Test Plan:
- BRAM model with lane value = (r*IN_W + c) & 8'h7F replicated across channels, m_ready=1 -> word 0 = 8'h0C in all lanes (pixel (1,1)=12). Last word = 8'h6C (pixel (9,9)=108). Exactly 400 words; m_last on the 400th; done pulse 1 cycle later.
- Quad values {-5, -128, -1, -100} in lane 2 of word 0 -> lane 2 = 8'hFF. With MAXPOOL_RELU_EN defined -> 8'h00.
- Random m_ready (50%) -> m_data stable while stalled. en never high during a stall. Output sequence identical to the m_ready=1 run.
- RD_LAT=2 build -> same 400 words. First m_valid 6 cycles after start.
- rst pulsed at output word 37, then start -> full 400-word pass from word 0, with no stale word emitted.
- start pulsed again at word 10 -> ignored. Word count stays 400 and there is exactly one done.
